// File: rtl/ascon_obi_arb_if.sv
// OBI request/response types and the bundle carrying the arbiter's upstream and downstream buses.
package ascon_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } mgr_obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic [3:0]  rid;
    } mgr_obi_rsp_t;
endpackage

interface ascon_obi_arb_if #(
    parameter int NumMgr = 5
);
    import ascon_obi_pkg::*;

    mgr_obi_req_t [NumMgr-1:0] up_req_i;
    mgr_obi_rsp_t [NumMgr-1:0] up_rsp_o;
    mgr_obi_req_t              dn_req_o;
    mgr_obi_rsp_t              dn_rsp_i;

    // slave: the arbiter; master: the DMA managers plus downstream subordinate
    modport slave  (input  up_req_i, input  dn_rsp_i, output up_rsp_o, output dn_req_o);
    modport master (output up_req_i, output dn_rsp_i, input  up_rsp_o, input  dn_req_o);
endinterface

// File: rtl/ascon_obi_arb.sv
// Round-robin OBI arbiter for NumMgr DMA managers onto one in-order bus; gnt/rvalid routed same cycle.
// Define ASCON_ARB_PRIO0_EN to give port 0 absolute priority in ARB (others stay round-robin).
module ascon_obi_arb
    import ascon_obi_pkg::*;
#(
    parameter int NumMgr         = 5,
    parameter int MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    ascon_obi_arb_if.slave                       bus,
    output logic                                 err_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);
    localparam int IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int PtrW = $clog2(MaxOutstanding);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic {ARB, HOLD} state_e;

    state_e          state_q;
    idx_t            sel_q;
    idx_t            last_q, last_d;
    idx_t            fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [NumMgr-1:0] req_vec;
    logic [NumMgr-1:0] rr_vec;
    idx_t              rr_idx;
    logic              rr_found;
    idx_t              sel;
    idx_t              head;
    logic              full;
    logic              dn_vld;
    logic              hs;
    logic              pop;
    idx_t              cidx;

    always_comb begin
        for (int i = 0; i < NumMgr; i++) begin
            req_vec[i] = bus.up_req_i[i].req;
        end
    end

    // Search begins one past the last granted port so every requester is reached within NumMgr grants.
    always_comb begin
        rr_vec   = req_vec;
        rr_idx   = '0;
        rr_found = 1'b0;
        cidx     = '0;
`ifdef ASCON_ARB_PRIO0_EN
        rr_vec[0] = 1'b0;
`endif
        for (int k = 0; k < NumMgr; k++) begin
            cidx = idx_t'((int'(last_q) + 1 + k) % NumMgr);
            if (!rr_found && rr_vec[cidx]) begin
                rr_idx   = cidx;
                rr_found = 1'b1;
            end
        end
`ifdef ASCON_ARB_PRIO0_EN
        if (req_vec[0]) begin
            rr_idx   = '0;
            rr_found = 1'b1;
        end
`endif
    end

    // A request already presented in HOLD stays up regardless of the outstanding limit.
    always_comb begin
        full   = (cnt_q == CntW'(MaxOutstanding));
        sel    = (state_q == HOLD) ? sel_q : rr_idx;
        dn_vld = rst_ni && ((state_q == HOLD) ? req_vec[sel_q] : (rr_found && !full));
        hs     = dn_vld && bus.dn_rsp_i.gnt;
        pop    = rst_ni && bus.dn_rsp_i.rvalid && (cnt_q != '0);
        head   = fifo_q[rptr_q];

        bus.dn_req_o     = bus.up_req_i[sel];
        bus.dn_req_o.req = dn_vld;

        for (int i = 0; i < NumMgr; i++) begin
            bus.up_rsp_o[i].rdata  = bus.dn_rsp_i.rdata;
            bus.up_rsp_o[i].rid    = bus.dn_rsp_i.rid;
            bus.up_rsp_o[i].gnt    = hs && (sel == idx_t'(i));
            bus.up_rsp_o[i].rvalid = pop && (head == idx_t'(i));
        end
    end

    always_comb begin
        last_d = hs ? sel : last_q;
        wptr_d = hs ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;
        cnt_d  = cnt_q + CntW'(hs) - CntW'(pop);
        err_d  = err_q || (bus.dn_rsp_i.rvalid && (cnt_q == '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            sel_q   <= '0;
            last_q  <= idx_t'(NumMgr - 1);
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            last_q <= last_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            case (state_q)
                ARB: begin
                    if (dn_vld && !bus.dn_rsp_i.gnt) begin
                        state_q <= HOLD;
                        sel_q   <= rr_idx;
                    end
                end
                HOLD: begin
                    if (hs) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Routing entries need no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wptr_q] <= sel;
        end
    end

    assign err_o         = err_q;
    assign outstanding_o = cnt_q;

endmodule
